mc_ctrl: RTL

- Multi-cycle control FSM for the single-ALU MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and write-back.
- Each cycle, drives the immediate extender mode (eop), ALU op, PC/IR/register-file/memory enables and the mux selects.
- Sits between the IR fields and the datapath; waits on a data-memory ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 101 ++++++++++
 rtl/mc_ctrl_decode.sv | 31 +++
 rtl/mc_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcode/funct
// constants, datapath select encodings and the per-instruction ALU/extender setup.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [4:0] RA_IDX = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_OR     = 3'b010;
  localparam logic [2:0] ALU_PASS_B = 3'b011;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] EOP_SIGN   = 2'b00;
  localparam logic [1:0] EOP_ZERO   = 2'b01;
  localparam logic [1:0] EOP_UPPER  = 2'b10;
  localparam logic [1:0] EOP_BRANCH = 2'b11;

  // One-hot instruction class; all-zero means illegal.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } instr_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic [1:0] eop;
  } alu_ctl_t;

  // ALU setup chosen in EX and held through MEM/WB so the ALU result stays stable.
  function automatic alu_ctl_t alu_ctl(instr_t i);
    alu_ctl_t c;
    c.alu_op    = ALU_ADD;
    c.alu_src_b = 1'b0;
    c.eop       = EOP_SIGN;
    if (i.subu) c.alu_op = ALU_SUB;
    if (i.ori) begin
      c.alu_op    = ALU_OR;
      c.alu_src_b = 1'b1;
      c.eop       = EOP_ZERO;
    end
    if (i.lui) begin
      c.alu_op    = ALU_PASS_B;
      c.alu_src_b = 1'b1;
      c.eop       = EOP_UPPER;
    end
    if (i.lw || i.sw) begin
      c.alu_op    = ALU_ADD;
      c.alu_src_b = 1'b1;
      c.eop       = EOP_SIGN;
    end
    if (i.beq) begin
      c.alu_op    = ALU_SUB;
      c.alu_src_b = 1'b0;
      c.eop       = EOP_BRANCH;
    end
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: op/funct to one-hot instruction class plus illegal flag.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [9:0] instr_o,
  output logic       illegal_o
);

  instr_t instr;
  logic   rtype;

  always_comb begin
    rtype      = (op_i == OP_RTYPE);
    instr.addu = rtype && (funct_i == FN_ADDU);
    instr.subu = rtype && (funct_i == FN_SUBU);
    instr.jr   = rtype && (funct_i == FN_JR);
    instr.ori  = (op_i == OP_ORI);
    instr.lui  = (op_i == OP_LUI);
    instr.lw   = (op_i == OP_LW);
    instr.sw   = (op_i == OP_SW);
    instr.beq  = (op_i == OP_BEQ);
    instr.j    = (op_i == OP_J);
    instr.jal  = (op_i == OP_JAL);
  end

  assign instr_o   = instr;
  assign illegal_o = ~|instr;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-ALU MIPS datapath (IF/ID/EX/MEM/WB).
// Outputs are combinational in state and IR fields, and forced low while in reset.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       ir_we,
  output logic [1:0] eop,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [2:0] state,
  output logic       illegal
);

  state_e   state_q, state_d;
  logic [9:0] instr_vec;
  instr_t   instr;
  logic     dec_illegal;
  alu_ctl_t actl;

  mc_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .instr_o   (instr_vec),
    .illegal_o (dec_illegal)
  );

  assign instr = instr_t'(instr_vec);
  assign actl  = alu_ctl(instr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIf;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = StIf;
    unique case (state_q)
      StIf: state_d = StId;
      StId: begin
        if (instr.j || instr.jal || instr.jr || dec_illegal) state_d = StIf;
        else                                                 state_d = StEx;
      end
      StEx: begin
        if (instr.addu || instr.subu || instr.ori || instr.lui) state_d = StWb;
        else if (instr.lw || instr.sw)                          state_d = StMem;
        else                                                    state_d = StIf;
      end
      StMem: begin
        if (!mem_ready && (instr.lw || instr.sw)) state_d = StMem;
        else if (mem_ready && instr.lw)           state_d = StWb;
        else                                      state_d = StIf;
      end
      StWb:    state_d = StIf;
      default: state_d = StIf;
    endcase
  end

  always_comb begin
    pc_we     = 1'b0;
    npc_sel   = NPC_SEQ;
    ir_we     = 1'b0;
    eop       = EOP_SIGN;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = REGDST_RT;
    wd_sel    = WD_ALU;
    illegal   = 1'b0;
    unique case (state_q)
      StIf: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      StId: begin
        if (instr.j || instr.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
        end
        if (instr.jal) begin
          reg_we  = 1'b1;
          reg_dst = REGDST_RA;
          wd_sel  = WD_PC;
        end
        if (instr.jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_RS;
        end
        illegal = dec_illegal;
      end
      StEx: begin
        {alu_op, alu_src_b, eop} = actl;
        if (instr.beq) begin
          pc_we   = zero;
          npc_sel = NPC_BRANCH;
        end
      end
      StMem: begin
        {alu_op, alu_src_b, eop} = actl;
        mem_req = 1'b1;
        mem_we  = instr.sw;
      end
      StWb: begin
        {alu_op, alu_src_b, eop} = actl;
        reg_we = 1'b1;
        if (instr.addu || instr.subu) reg_dst = REGDST_RD;
        if (instr.lw)                 wd_sel  = WD_MEM;
      end
      default: ;
    endcase
    // Nothing may leak to the datapath while reset is held, even mid-instruction.
    if (!reset_n) begin
      pc_we     = 1'b0;
      npc_sel   = 2'b00;
      ir_we     = 1'b0;
      eop       = 2'b00;
      alu_src_b = 1'b0;
      alu_op    = 3'b000;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      reg_dst   = 2'b00;
      wd_sel    = 2'b00;
      illegal   = 1'b0;
    end
  end

  assign state = reset_n ? state_q : 3'd0;

endmodule
